reg_share_arbiter: RTL

Round-robin arbiter and write sequencer that shares one 32-bit PIPO register among NREQ requesters. It holds the shared register value, grants at most one write per cycle with a valid/ready handshake, and tags the current owner. It also supports an optional multi-cycle lock with a timeout watchdog. It sits between requester pipelines and the register datapath and is the only writer of that register.

---
 rtl/reg_share_arbiter_pkg.sv | 19 +
 rtl/reg_share_arbiter_if.sv | 29 ++
 rtl/reg_share_arbiter_rr_pick.sv | 31 +++
 rtl/reg_share_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and constants for the reg_share_arbiter slice.
// The lock/watchdog feature is compiled in only when REG_SHARE_LOCK_EN is defined.
package reg_share_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_MAX_LOCK = 16;

    // Owner index width; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: write requests in, grant and register state out.
// The req_lock lane is meaningful only in builds with REG_SHARE_LOCK_EN defined.
interface reg_share_arbiter_if #(
    parameter int NREQ  = reg_share_pkg::DEF_NREQ,
    parameter int WIDTH = reg_share_pkg::DEF_WIDTH
);
    localparam int IW = reg_share_pkg::owner_w(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      q;
    logic [IW-1:0]         q_owner;
    logic                  wr_pulse;
    logic                  lock_active;
    logic                  lock_err;

    modport master (
        output req_valid, req_lock, req_data,
        input  req_ready, q, q_owner, wr_pulse, lock_active, lock_err
    );

    modport slave (
        input  req_valid, req_lock, req_data,
        output req_ready, q, q_owner, wr_pulse, lock_active, lock_err
    );

endinterface

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after ptr wins.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            found
);

    // Walk the request vector once, starting at the pointer and wrapping.
    always_comb begin
        int pos_s;
        pos_s = 0;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos_s = (int'(ptr) + k) % NREQ;
            if (!found && req[pos_s]) begin
                gnt[pos_s] = 1'b1;
                idx        = IW'(pos_s);
                found      = 1'b1;
            end else begin
            end
        end
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter and sole writer of a shared PIPO register.
// Define REG_SHARE_LOCK_EN to build the multi-cycle lock with its timeout watchdog.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input logic                 clk,
    input logic                 rst,
    reg_share_arbiter_if.slave  bus
);

    localparam int IW = owner_w(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    if (NREQ < 2 || NREQ > 8 || MAX_LOCK < 1) begin : g_param_chk
        $error("reg_share_arbiter: NREQ must be 2..8 and MAX_LOCK >= 1");
    end

    logic [WIDTH-1:0] q_r;
    logic [IW-1:0]    owner_r;
    logic [IW-1:0]    ptr_r;
    logic             wr_pulse_r;

    logic [NREQ-1:0]  pick_req_s;
    logic [NREQ-1:0]  gnt_s;
    logic [IW-1:0]    gnt_idx_s;
    logic             acc_s;
    logic [WIDTH-1:0] wdata_s;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end else begin
            return i + IW'(1'b1);
        end
    endfunction

`ifdef REG_SHARE_LOCK_EN
    state_e          state_r;
    logic [CW-1:0]   lock_cnt_r;
    logic            lock_active_r;
    logic            lock_err_r;
    logic [NREQ-1:0] owner_oh_s;
    logic            lock_sel_s;
    logic            wd_fire_s;

    // While locked only the owner's lane reaches the picker; others keep waiting.
    assign owner_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
    assign pick_req_s = (state_r == LOCKED) ? (bus.req_valid & owner_oh_s) : bus.req_valid;
    assign lock_sel_s = bus.req_lock[gnt_idx_s];
    // An owner write in the final allowed cycle beats the timeout.
    assign wd_fire_s  = (state_r == LOCKED) && !acc_s && (lock_cnt_r == CW'(MAX_LOCK - 1));
    assign bus.lock_active = lock_active_r;
    assign bus.lock_err    = lock_err_r;
`else
    assign pick_req_s      = bus.req_valid;
    assign bus.lock_active = 1'b0;
    assign bus.lock_err    = 1'b0;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (pick_req_s),
        .ptr   (ptr_r),
        .gnt   (gnt_s),
        .idx   (gnt_idx_s),
        .found (acc_s)
    );

    assign wdata_s       = bus.req_data[int'(gnt_idx_s) * WIDTH +: WIDTH];
    assign bus.req_ready = rst ? gnt_s : '0;
    assign bus.q         = q_r;
    assign bus.q_owner   = owner_r;
    assign bus.wr_pulse  = wr_pulse_r;

    // Register update, round-robin pointer and lock state machine.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r           <= '0;
            owner_r       <= '0;
            ptr_r         <= '0;
            wr_pulse_r    <= 1'b0;
`ifdef REG_SHARE_LOCK_EN
            state_r       <= IDLE;
            lock_cnt_r    <= '0;
            lock_active_r <= 1'b0;
            lock_err_r    <= 1'b0;
`endif
        end else begin
            wr_pulse_r <= acc_s;
            if (acc_s) begin
                q_r     <= wdata_s;
                owner_r <= gnt_idx_s;
                ptr_r   <= next_idx(gnt_idx_s);
`ifdef REG_SHARE_LOCK_EN
            end else if (wd_fire_s) begin
                ptr_r   <= next_idx(owner_r);
`endif
            end else begin
            end
`ifdef REG_SHARE_LOCK_EN
            lock_err_r <= wd_fire_s;
            case (state_r)
                IDLE: begin
                    lock_cnt_r <= '0;
                    if (acc_s && lock_sel_s) begin
                        state_r       <= LOCKED;
                        lock_active_r <= 1'b1;
                    end else begin
                        state_r       <= IDLE;
                        lock_active_r <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (acc_s) begin
                        lock_cnt_r    <= '0;
                        state_r       <= lock_sel_s ? LOCKED : IDLE;
                        lock_active_r <= lock_sel_s;
                    end else if (wd_fire_s) begin
                        lock_cnt_r    <= '0;
                        state_r       <= IDLE;
                        lock_active_r <= 1'b0;
                    end else begin
                        lock_cnt_r    <= lock_cnt_r + CW'(1'b1);
                        state_r       <= LOCKED;
                        lock_active_r <= 1'b1;
                    end
                end
                default: begin
                    lock_cnt_r    <= '0;
                    state_r       <= IDLE;
                    lock_active_r <= 1'b0;
                end
            endcase
`endif
        end
    end

endmodule
